// File: rtl/scmp_bus_if_if.sv
// Synchronous req/ack memory port carried by the SC/MP bus interface.
// master = bus interface side, slave = memory side.
interface scmp_bus_if_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/scmp_bus_if.sv
// SC/MP multiplexed-bus demux and req/ack transaction engine with core stall.
// Optional halt support is compiled in with the SCMP_BUS_HALT_EN macro.
module scmp_bus_if #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [7:0]  ERR_RDATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_D_o,
  output logic [7:0]  cpu_D_i,
  input  logic        cpu_ADS_n,
  input  logic        cpu_RD_n,
  input  logic        cpu_WR_n,
  output logic        cpu_hold,
  scmp_bus_if_if.master mem,
  output logic [3:0]  cyc_flags,
  output logic        bus_err,
  output logic        halted,
  input  logic        cont_i
);

  typedef enum logic [2:0] {IDLE, ADDR, REQ, DONE, HALT} state_e;

  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [3:0]  flags_q;
  logic        req_q;
  logic        we_q;
  logic        err_q;

  logic        rd, wr, ads, strb_idle;
  logic [15:0] addr_d;
  logic [3:0]  flags_d;

  assign rd        = !cpu_RD_n;
  assign wr        = !cpu_WR_n;
  assign ads       = !cpu_ADS_n;
  assign strb_idle = cpu_RD_n && cpu_WR_n;
  // During ADS_n the data bus carries {H,D,I,R,A15..A12}.
  assign addr_d    = {cpu_D_o[3:0], cpu_addr};
  assign flags_d   = cpu_D_o[7:4];

`ifdef SCMP_BUS_HALT_EN
  logic halted_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      flags_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef SCMP_BUS_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ads) begin
            addr_q  <= addr_d;
            flags_q <= flags_d;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (rd || wr) begin
            // Read wins when both strobes are low.
            req_q   <= 1'b1;
            we_q    <= !rd;
            cnt_q   <= TO_LOAD;
            state_q <= REQ;
            if (!rd) wdata_q <= cpu_D_o;
          end else if (ads) begin
            addr_q  <= addr_d;
            flags_q <= flags_d;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) rdata_q <= mem.mem_rdata;
          end else if (cnt_q == 8'd0) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
            if (!we_q) rdata_q <= ERR_RDATA;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          if (strb_idle) begin
`ifdef SCMP_BUS_HALT_EN
            if (flags_q[3]) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else
`endif
            if (ads) begin
              addr_q  <= addr_d;
              flags_q <= flags_d;
              state_q <= ADDR;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HALT: begin
`ifdef SCMP_BUS_HALT_EN
          if (cont_i) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational so the core stalls in the strobe's very first cycle.
  assign cpu_hold = (state_q == ADDR && (rd || wr)) || state_q == REQ || state_q == HALT;

  assign cpu_D_i       = rdata_q;
  assign cyc_flags     = flags_q;
  assign bus_err       = err_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;

`ifdef SCMP_BUS_HALT_EN
  assign halted = halted_q;
`else
  logic unused_cont;
  assign unused_cont = cont_i;
  assign halted      = 1'b0;
`endif

endmodule
